// File: rtl/counter_modn_ud_if.sv
// Control and status bundle for counter_modn_ud.
// The master side drives the count controls; the slave side (the counter) returns count and flags.
interface counter_modn_ud_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clr_flag;
  logic [WIDTH-1:0] count;
  logic             carry_out;
  logic             borrow_out;
  logic             wrapped;

  modport master (
    output enable, up_down, load, load_value, clr_flag,
    input  count, carry_out, borrow_out, wrapped
  );

  modport slave (
    input  enable, up_down, load, load_value, clr_flag,
    output count, carry_out, borrow_out, wrapped
  );
endinterface

// File: rtl/counter_modn_ud.sv
// Mod-N up/down counter with sticky wrap flag; clamped parallel load only when COUNTER_MODN_UD_LOAD_EN is defined.
// All outputs registered (one-edge latency); no backpressure, every enabled edge takes a step.
module counter_modn_ud #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             Reset,
  counter_modn_ud_if.slave bus
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             wrapped_q, wrapped_d;

`ifdef COUNTER_MODN_UD_LOAD_EN
  // Compare one bit wider so MODULUS = 2^WIDTH never clamps.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);
  logic [WIDTH-1:0] load_clamped;
  assign load_clamped = ({1'b0, bus.load_value} >= MOD_EXT) ? TOP : bus.load_value;
`else
  logic load_unused;
  assign load_unused = ^{bus.load, bus.load_value};
`endif

  always_comb begin
    count_d   = count_q;
    carry_d   = 1'b0;
    borrow_d  = 1'b0;
    wrapped_d = wrapped_q;
    if (bus.clr_flag) begin
      wrapped_d = 1'b0;
    end
`ifdef COUNTER_MODN_UD_LOAD_EN
    if (bus.load) begin
      count_d = load_clamped;
    end else if (bus.enable) begin
`else
    if (bus.enable) begin
`endif
      if (bus.up_down) begin
        if (count_q == TOP) begin
          count_d   = '0;
          carry_d   = 1'b1;
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d   = TOP;
          borrow_d  = 1'b1;
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      count_q   <= '0;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      carry_q   <= carry_d;
      borrow_q  <= borrow_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.carry_out  = carry_q;
  assign bus.borrow_out = borrow_q;
  assign bus.wrapped    = wrapped_q;

endmodule
